// File: rtl/afu_rd_rsp_reorder_pkg.sv
// Shared types for the channel-0 read path: tag width, mdata and cache-line types.
// Holds the tag-to-mdata helper used when building read request headers.
// Only declarations live here; no logic and no state.
package afu_rd_rsp_reorder_pkg;

  localparam int CACHE_WIDTH = 512;
  localparam int MDATA_WIDTH = 16;
  localparam int RD_TAG_BITS = 4;

  typedef logic [MDATA_WIDTH-1:0] t_cci_mdata;
  typedef logic [RD_TAG_BITS-1:0] t_rd_tag;
  typedef logic [CACHE_WIDTH-1:0] t_cache_line;

  // Header fields the requester fills in for a c0 read.
  typedef struct packed {
    logic [41:0] address;
    t_cci_mdata  metadata;
  } rd_req_hdr_config_t;

  // Read tags ride in the low bits of mdata; upper bits are zero.
  function automatic t_cci_mdata tagToMdata(input t_rd_tag tag);
    return t_cci_mdata'(tag);
  endfunction

endpackage

// File: rtl/afu_rd_rsp_reorder_line_ram.sv
// Tagged line storage for the read reorder buffer: one write port, one read port.
// Latency: write visible on the read port the cycle after the write edge; read is combinational.
// No flow control; the owner guarantees a slot is never written while it is being drained.
module afu_line_ram #(
  parameter int ADDR_BITS = 4,
  parameter int WIDTH     = 512
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_BITS];

  // Store an accepted response line into its tag slot.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/afu_rd_rsp_reorder.sv
// Reorders out-of-order c0 read responses back into request order using mdata tags.
// Latency: a response to the head tag appears on out_valid the following cycle.
// out_ready low holds the head line stable; req_ready drops when all tags are in flight.
module afu_rd_rsp_reorder
  import afu_rd_rsp_reorder_pkg::*;
#(
  parameter int TAG_BITS = RD_TAG_BITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  output logic [TAG_BITS-1:0]    req_tag,
  input  logic                   rsp_valid,
  input  logic [MDATA_WIDTH-1:0] rsp_mdata,
  input  logic [CACHE_WIDTH-1:0] rsp_data,
  output logic                   out_valid,
  output logic [CACHE_WIDTH-1:0] out_data,
  input  logic                   out_ready,
  output logic [TAG_BITS:0]      outstanding,
  output logic                   err_unexpected
);

  localparam int DEPTH = 2**TAG_BITS;

  // Pointers carry one extra bit so that full and empty are distinguishable.
  logic [TAG_BITS:0]   alloc_ptr;
  logic [TAG_BITS:0]   head_ptr;
  logic [DEPTH-1:0]    pending;
  logic [DEPTH-1:0]    filled;
  logic [TAG_BITS-1:0] head_idx;
  logic [TAG_BITS-1:0] rsp_tag;
  logic                do_alloc;
  logic                do_pop;
  logic                rsp_accept;
  logic                unused_mdata_hi;

  assign outstanding = alloc_ptr - head_ptr;
  assign req_ready   = (outstanding != (TAG_BITS+1)'(DEPTH));
  assign req_tag     = alloc_ptr[TAG_BITS-1:0];
  assign head_idx    = head_ptr[TAG_BITS-1:0];
  assign rsp_tag     = rsp_mdata[TAG_BITS-1:0];
  assign out_valid   = filled[head_idx];

  assign do_alloc    = req_valid & req_ready;
  assign do_pop      = out_valid & out_ready;
  // A line is only accepted for a tag that was handed out and has not yet been filled;
  // this also rejects a response racing the pop of its own head slot.
  assign rsp_accept  = rsp_valid & pending[rsp_tag] & ~filled[rsp_tag];

  // Upper mdata bits belong to other users of the field and are deliberately ignored.
  assign unused_mdata_hi = ^rsp_mdata[MDATA_WIDTH-1:TAG_BITS];

  afu_line_ram #(
    .ADDR_BITS (TAG_BITS),
    .WIDTH     (CACHE_WIDTH)
  ) u_line_ram (
    .clk   (clk),
    .we    (rsp_accept),
    .waddr (rsp_tag),
    .wdata (rsp_data),
    .raddr (head_idx),
    .rdata (out_data)
  );

  // Tag bookkeeping: pop clears the head first, so an allocate of the same slot wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      alloc_ptr      <= '0;
      head_ptr       <= '0;
      pending        <= '0;
      filled         <= '0;
      err_unexpected <= 1'b0;
    end else begin
      if (do_pop) begin
        pending[head_idx] <= 1'b0;
        filled[head_idx]  <= 1'b0;
        head_ptr          <= head_ptr + (TAG_BITS+1)'(1);
      end
      if (do_alloc) begin
        pending[alloc_ptr[TAG_BITS-1:0]] <= 1'b1;
        alloc_ptr                        <= alloc_ptr + (TAG_BITS+1)'(1);
      end
      if (rsp_accept) begin
        filled[rsp_tag] <= 1'b1;
      end
      if (rsp_valid && !rsp_accept) begin
        err_unexpected <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_afu_rd_rsp_reorder.sv
// Directed scoreboard bench for the read response reorder buffer.
// Allocation pushes the line the requester expects back; a monitor pops on each output handshake.
// Status outputs are checked against hand-derived values at fixed points.
module tb_afu_rd_rsp_reorder;
  import afu_rd_rsp_reorder_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [3:0]   req_tag;
  logic         rsp_valid = 1'b0;
  logic [15:0]  rsp_mdata = '0;
  logic [511:0] rsp_data = '0;
  logic         out_valid;
  logic [511:0] out_data;
  logic         out_ready = 1'b0;
  logic [4:0]   outstanding;
  logic         err_unexpected;

  int           checks = 0;
  int           errors = 0;
  int           nxt_tag = 0;
  logic [511:0] exp_q[$];
  logic [511:0] tag_data[16];

  always #5 clk = ~clk;

  afu_rd_rsp_reorder #(.TAG_BITS(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_tag        (req_tag),
    .rsp_valid      (rsp_valid),
    .rsp_mdata      (rsp_mdata),
    .rsp_data       (rsp_data),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ready      (out_ready),
    .outstanding    (outstanding),
    .err_unexpected (err_unexpected)
  );

  function automatic logic [511:0] line_of(input int tag, input logic [7:0] salt);
    logic [7:0] b;
    b = 8'(tag * 17) ^ salt;
    return {64{b}};
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) tick();
    reset = 1'b0;
    nxt_tag = 0;
  endtask

  // Issue one read; the line this tag will carry is queued as the next in-order output.
  task automatic alloc(input logic [7:0] salt);
    int t;
    t = nxt_tag % 16;
    chk("alloc_ready", req_ready, 1);
    chk("alloc_tag", req_tag, t);
    tag_data[t] = line_of(t, salt);
    exp_q.push_back(tag_data[t]);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    nxt_tag++;
  endtask

  task automatic respond_raw(input logic [15:0] mdata, input logic [511:0] data);
    rsp_valid = 1'b1;
    rsp_mdata = mdata;
    rsp_data  = data;
    tick();
    rsp_valid = 1'b0;
  endtask

  // Upper mdata bits are junk on purpose; only the low tag bits matter.
  task automatic respond(input int tag);
    respond_raw({12'hA5C, 4'(tag)}, tag_data[tag]);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 64) begin
      tick();
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (!reset && out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            chk("out_data", out_data, exp_q.pop_front());
          end
        end
      end
    join_none

    // Reset state
    do_reset(2);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_req_tag", req_tag, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err_unexpected, 0);

    // In order: each line shows up the cycle after its response
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) alloc(8'h00);
    chk("io_outstanding4", outstanding, 4);
    for (int i = 0; i < 4; i++) begin
      respond(i);
      chk("io_valid_next", out_valid, 1);
    end
    wait_drain();
    tick();
    chk("io_outstanding0", outstanding, 0);
    chk("io_valid_idle", out_valid, 0);

    // Reorder: nothing leaves until tag 0 arrives, then four back-to-back pops
    do_reset(1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) alloc(8'h3C);
    respond(3);
    chk("ro_hold3", out_valid, 0);
    respond(1);
    chk("ro_hold1", out_valid, 0);
    respond(2);
    chk("ro_hold2", out_valid, 0);
    respond(0);
    for (int i = 0; i < 4; i++) begin
      chk("ro_burst_valid", out_valid, 1);
      tick();
    end
    chk("ro_done_valid", out_valid, 0);
    chk("ro_outstanding0", outstanding, 0);
    chk("ro_q_empty", exp_q.size(), 0);

    // Full: sixteen in flight, illegal request ignored, one pop reopens tag 0
    do_reset(1);
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) alloc(8'hA5);
    chk("full_ready", req_ready, 0);
    chk("full_outstanding", outstanding, 16);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("full_illegal_req", outstanding, 16);
    respond(0);
    chk("full_head_valid", out_valid, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("full_reopen_ready", req_ready, 1);
    chk("full_wrap_tag", req_tag, 0);
    chk("full_outstanding15", outstanding, 15);
    alloc(8'h5A);
    chk("full_again", req_ready, 0);
    out_ready = 1'b1;
    for (int i = 1; i < 16; i++) respond(i);
    respond(0);
    wait_drain();
    tick();
    chk("full_drained", outstanding, 0);

    // Backpressure: head held stable, then pop together with a new allocation
    do_reset(1);
    out_ready = 1'b0;
    alloc(8'h77);
    alloc(8'h77);
    respond(0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid_held", out_valid, 1);
      chk("bp_data_held", out_data, line_of(0, 8'h77));
      tick();
    end
    out_ready = 1'b1;
    alloc(8'h77);
    out_ready = 1'b0;
    chk("bp_alloc_pop_outstanding", outstanding, 2);
    chk("bp_next_not_ready", out_valid, 0);
    respond(2);
    respond(1);
    out_ready = 1'b1;
    wait_drain();

    // Unexpected responses: unallocated tag, then a duplicate of a filled tag
    do_reset(1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) alloc(8'h42);
    respond(2);
    chk("ux_err_clear", err_unexpected, 0);
    respond_raw(16'hAB05, {64{8'hEE}});
    chk("ux_err_tag5", err_unexpected, 1);
    respond_raw(16'h0012, {64{8'hDD}});
    chk("ux_err_dup", err_unexpected, 1);
    chk("ux_outstanding", outstanding, 3);
    chk("ux_head_empty", out_valid, 0);
    respond(0);
    respond(1);
    out_ready = 1'b1;
    wait_drain();
    chk("ux_err_sticky", err_unexpected, 1);

    // Reset mid-flight discards everything; a stale response is then unexpected
    do_reset(1);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) alloc(8'h99);
    respond(1);
    respond(3);
    respond_raw(16'h0009, {64{8'h11}});
    chk("mf_outstanding6", outstanding, 6);
    chk("mf_no_head", out_valid, 0);
    chk("mf_err_set", err_unexpected, 1);
    exp_q.delete();
    do_reset(1);
    chk("mf_out_valid", out_valid, 0);
    chk("mf_outstanding", outstanding, 0);
    chk("mf_req_tag", req_tag, 0);
    chk("mf_req_ready", req_ready, 1);
    chk("mf_err", err_unexpected, 0);
    respond_raw(16'h0003, {64{8'h33}});
    chk("mf_stale_err", err_unexpected, 1);
    chk("mf_stale_no_out", out_valid, 0);

    tick();
    chk("final_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
